l2_fifo_mc: RTL and testbench
=============================

# l2_fifo_mc

Multi-channel synchronous FIFO for the L2 arbiter: NUM_CHANNELS independent logical queues of FIFO_DEPTH entries each, sharing one write port and one read port, with per-channel occupancy counts, almost-full flags and sticky overflow/underflow error reporting. It is the parametrised successor to the single-queue L2 FIFO. The arbiter uses it to buffer per-port requests or responses without instantiating one FIFO per port. Depth need not be a power of two.

## Interface
- DATA_WIDTH, 32, entry width in bits
- FIFO_DEPTH, 4, entries per channel, ≥2, any integer
- NUM_CHANNELS, 4, logical queues, ≥1
- ALMOST_FULL, FIFO_DEPTH-1, count threshold for almost_full, 1..FIFO_DEPTH
- Derived: CH_W = max(1, $clog2(NUM_CHANNELS)); CNT_W = $clog2(FIFO_DEPTH+1)

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- push  in  1  write request
- push_id  in  CH_W  target channel of push
- data_in  in  DATA_WIDTH  write data
- pop  in  1  read/advance request
- pop_id  in  CH_W  channel read and popped
- data_out  out  DATA_WIDTH  head entry of channel pop_id (fall-through)
- valid  out  NUM_CHANNELS  channel non-empty
- full  out  NUM_CHANNELS  channel count == FIFO_DEPTH
- almost_full  out  NUM_CHANNELS  channel count ≥ ALMOST_FULL
- count  out  NUM_CHANNELS×CNT_W  per-channel occupancy
- overflow  out  1  sticky: a push was dropped
- underflow  out  1  sticky: a pop hit an empty channel
- clear_err  in  1  synchronous clear of overflow/underflow

## Operation
- Per channel: read index, write index, count. Indices wrap FIFO_DEPTH-1 → 0 (explicit compare, not modulo-2^n).
- Storage: NUM_CHANNELS×FIFO_DEPTH entries, addressed {channel, index}; not reset.
- data_out = storage[pop_id][rd_idx[pop_id]] combinationally. It is undefined when valid[pop_id]=0.
- Push accepted if !full[push_id], or if full[push_id] && pop && pop_id==push_id && valid[pop_id]. Accepted push writes at wr_idx and increments wr_idx.
- Push rejected otherwise. Storage and indices are unchanged and overflow is set.
- Pop effective if valid[pop_id]: increments rd_idx. Pop on an empty channel is ignored and sets underflow.
- Count per channel: +1 on accepted push only, −1 on effective pop only, unchanged when both hit the same channel. Different-channel push/pop update both independently.
- Push to an empty channel with a same-cycle pop on that channel: the pop is ineffective (underflow set), the push is accepted, and count becomes 1.
- overflow/underflow: set has priority over clear_err in the same cycle.
- No further state machine: pure pointer/counter datapath.

## Timing
- Reset (async assert, sync-safe deassert by system): all counts 0, indices 0, valid=0, full=0, almost_full=0, overflow=0, underflow=0. data_out is don't-care.
- Write-to-read latency 1: data pushed at edge N is visible on data_out (pop_id selecting that channel, previously empty) after edge N.
- Flags (valid, full, almost_full, count) are registered-state derived and update 1 cycle after the causing edge. They are never combinational from push/pop.
- Pop changes data_out to the next entry after the edge.
- Reset asserted mid-operation discards all queued entries immediately (asynchronously). Outputs reach reset values without waiting for clk.

## Structure
- Put no new package types in the shared package; CH_W/CNT_W are localparams.
- Sub-module l2_fifo_mc_ctrl: one channel's rd/wr index, count, flags and accept logic. Instantiate with a generate loop, NUM_CHANNELS times.
- The top level holds storage, the data_out mux, and the error flags.

## Test plan
- Reset then push ch2 values 0xA0..0xA3 (DEPTH=4): full[2]=1, count[2]=4, other channels count 0; pop ch2 ×4 returns 0xA0..0xA3 in order, valid[2]=0 after.
- DEPTH=3 wrap: 10 push/pop cycles on ch0 with values 1..10 → read order 1..10, indices wrap 2→0, count never exceeds 3.
- ch1 full, push ch1 0x55 without pop → overflow=1, contents unchanged. Then push 0x66 with pop ch1 same cycle → accepted, count stays 4, 0x66 is last out.
- Pop empty ch3 → underflow=1, count[3]=0. Assert clear_err with no error → both flags 0 next cycle.
- Simultaneous push ch0 and pop ch1 (ch1 count 2) → count[0]+1, count[1]−1. almost_full[0] asserts when count[0] reaches ALMOST_FULL=3.
- Fill ch0 to 2 entries, assert rst between edges → all outputs reset without a clock edge. After release, a push of 0x7 on ch0 reads back 0x7 first.

Source files
------------

// File: rtl/l2_fifo_mc_pkg.sv
// l2_fifo_mc shared helpers
// Width helpers used by the multi-channel FIFO and its channel control.
package l2_fifo_mc_pkg;

    // Index width that never collapses to zero bits.
    function automatic int clamp_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2_fifo_mc_ctrl.sv
// l2_fifo_mc_ctrl: one channel's indices, count, flags and push accept.
// Pure pointer/counter datapath; storage lives in the top level.
module l2_fifo_mc_ctrl
    import l2_fifo_mc_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ALMOST_FULL = FIFO_DEPTH - 1,
    localparam int IDX_W = clamp_w(FIFO_DEPTH),
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_hit,
    input  logic             pop_hit,
    output logic [IDX_W-1:0] rd_idx,
    output logic [IDX_W-1:0] wr_idx,
    output logic [CNT_W-1:0] count,
    output logic             valid,
    output logic             full,
    output logic             almost_full,
    output logic             push_ok
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(FIFO_DEPTH - 1);

    logic pop_ok;

    // Flags come from the registered count only.
    always_comb begin
        valid       = (count != '0);
        full        = (count == CNT_W'(FIFO_DEPTH));
        almost_full = (count >= CNT_W'(ALMOST_FULL));
        pop_ok      = pop_hit && valid;
        push_ok     = push_hit && (!full || pop_ok);
    end

    // Index and occupancy update; indices wrap at the last slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx <= '0;
            wr_idx <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_idx <= (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
            if (pop_ok)
                rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/l2_fifo_mc.sv
// l2_fifo_mc: multi-channel FIFO with shared write/read ports.
// Holds storage, the fall-through read mux and sticky error flags.
module l2_fifo_mc
    import l2_fifo_mc_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int NUM_CHANNELS = 4,
    parameter int ALMOST_FULL  = FIFO_DEPTH - 1,
    localparam int CH_W  = clamp_w(NUM_CHANNELS),
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1),
    localparam int IDX_W = clamp_w(FIFO_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [CH_W-1:0]               push_id,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          pop,
    input  logic [CH_W-1:0]               pop_id,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic [NUM_CHANNELS-1:0]       valid,
    output logic [NUM_CHANNELS-1:0]       full,
    output logic [NUM_CHANNELS-1:0]       almost_full,
    output logic [NUM_CHANNELS*CNT_W-1:0] count,
    output logic                          overflow,
    output logic                          underflow,
    input  logic                          clear_err
);

    logic [DATA_WIDTH-1:0]   mem [NUM_CHANNELS][FIFO_DEPTH];
    logic [IDX_W-1:0]        rd_idx [NUM_CHANNELS];
    logic [IDX_W-1:0]        wr_idx [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] push_ok;
    logic                    push_acc;
    logic                    set_ov;
    logic                    set_un;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        l2_fifo_mc_ctrl #(
            .FIFO_DEPTH  (FIFO_DEPTH),
            .ALMOST_FULL (ALMOST_FULL)
        ) u_ctrl (
            .clk         (clk),
            .rst         (rst),
            .push_hit    (push && (push_id == CH_W'(g))),
            .pop_hit     (pop && (pop_id == CH_W'(g))),
            .rd_idx      (rd_idx[g]),
            .wr_idx      (wr_idx[g]),
            .count       (count[g*CNT_W +: CNT_W]),
            .valid       (valid[g]),
            .full        (full[g]),
            .almost_full (almost_full[g]),
            .push_ok     (push_ok[g])
        );
    end

    // Fall-through head of the selected channel plus error set terms.
    always_comb begin
        data_out = mem[pop_id][rd_idx[pop_id]];
        push_acc = |push_ok;
        set_ov   = push && !push_acc;
        set_un   = pop && !valid[pop_id];
    end

    // Storage write; contents are not reset.
    always_ff @(posedge clk) begin
        if (push_acc)
            mem[push_id][wr_idx[push_id]] <= data_in;
    end

    // Sticky error flags; a new error wins over clear_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (set_ov)
                overflow <= 1'b1;
            else if (clear_err)
                overflow <= 1'b0;
            if (set_un)
                underflow <= 1'b1;
            else if (clear_err)
                underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_l2_fifo_mc.sv
// tb_l2_fifo_mc: directed test of l2_fifo_mc (depth 4 and depth 3).
// Both instances share stimulus; the depth-3 one is checked in the wrap test.
module tb_l2_fifo_mc;

    logic        clk;
    logic        rst;
    logic        push;
    logic [1:0]  push_id;
    logic [31:0] data_in;
    logic        pop;
    logic [1:0]  pop_id;
    logic        clear_err;

    logic [31:0] data_out;
    logic [3:0]  valid;
    logic [3:0]  full;
    logic [3:0]  almost_full;
    logic [11:0] count;
    logic        overflow;
    logic        underflow;

    logic [31:0] d3_out;
    logic [3:0]  v3;
    logic [3:0]  f3;
    logic [3:0]  af3;
    logic [7:0]  c3;
    logic        ov3;
    logic        un3;

    int total = 0;
    int bad   = 0;

    l2_fifo_mc #(
        .DATA_WIDTH   (32),
        .FIFO_DEPTH   (4),
        .NUM_CHANNELS (4),
        .ALMOST_FULL  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_id     (push_id),
        .data_in     (data_in),
        .pop         (pop),
        .pop_id      (pop_id),
        .data_out    (data_out),
        .valid       (valid),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .clear_err   (clear_err)
    );

    l2_fifo_mc #(
        .DATA_WIDTH   (32),
        .FIFO_DEPTH   (3),
        .NUM_CHANNELS (4)
    ) dut3 (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_id     (push_id),
        .data_in     (data_in),
        .pop         (pop),
        .pop_id      (pop_id),
        .data_out    (d3_out),
        .valid       (v3),
        .full        (f3),
        .almost_full (af3),
        .count       (c3),
        .overflow    (ov3),
        .underflow   (un3),
        .clear_err   (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push      = 1'b0;
        pop       = 1'b0;
        clear_err = 1'b0;
    endtask

    function automatic logic [2:0] cnt(input int ch);
        return count[ch*3 +: 3];
    endfunction

    initial begin
        rst       = 1'b1;
        push      = 1'b0;
        push_id   = '0;
        data_in   = '0;
        pop       = 1'b0;
        pop_id    = '0;
        clear_err = 1'b0;
        #2;
        chk("rst_valid", valid, 4'h0);
        chk("rst_full", full, 4'h0);
        chk("rst_afull", almost_full, 4'h0);
        chk("rst_count", count, 12'h0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_unf", underflow, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Fill channel 2 with A0..A3.
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; push_id = 2'd2; data_in = 32'hA0 + 32'(i);
            step();
            if (i == 0) begin
                pop_id = 2'd2;
                #0;
                chk("lat1_data", data_out, 32'hA0);
                chk("lat1_valid", valid, 4'h4);
            end
        end
        idle();
        #1;
        chk("ch2_full", full, 4'h4);
        chk("ch2_count", count, 12'h100);
        chk("ch2_afull", almost_full, 4'h4);

        // Drain channel 2 in order.
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1; pop_id = 2'd2;
            #1;
            chk("ch2_pop_data", data_out, 32'hA0 + 32'(i));
            step();
        end
        idle();
        #1;
        chk("ch2_empty", valid, 4'h0);

        // Fill channel 1, then overflow it.
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; push_id = 2'd1; data_in = 32'h11 * 32'(i + 1);
            step();
        end
        push = 1'b1; push_id = 2'd1; data_in = 32'h55;
        step();
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_cnt1", cnt(1), 3'd4);

        // Push into full ch1 with same-cycle pop: accepted.
        push = 1'b1; push_id = 2'd1; data_in = 32'h66;
        pop = 1'b1; pop_id = 2'd1;
        #1;
        chk("fullpp_head", data_out, 32'h11);
        step();
        idle();
        chk("fullpp_cnt", cnt(1), 3'd4);
        chk("ovf_sticky", overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1; pop_id = 2'd1;
            #1;
            chk("ch1_order", data_out,
                (i == 3) ? 32'h66 : 32'h11 * 32'(i + 2));
            step();
        end
        idle();
        #1;
        chk("ch1_drained", cnt(1), 3'd0);

        // Underflow on empty ch3, then clear.
        pop = 1'b1; pop_id = 2'd3;
        step();
        idle();
        chk("unf_set", underflow, 1'b1);
        chk("unf_cnt3", cnt(3), 3'd0);
        clear_err = 1'b1;
        step();
        idle();
        chk("clr_ovf", overflow, 1'b0);
        chk("clr_unf", underflow, 1'b0);

        // Error set beats clear_err in the same cycle.
        pop = 1'b1; pop_id = 2'd3; clear_err = 1'b1;
        step();
        idle();
        chk("set_prio", underflow, 1'b1);
        clear_err = 1'b1;
        step();
        idle();

        // Different-channel push/pop; almost_full at 3.
        for (int i = 0; i < 2; i++) begin
            push = 1'b1; push_id = 2'd0; data_in = 32'h20 + 32'(i);
            step();
            push = 1'b1; push_id = 2'd1; data_in = 32'h40 + 32'(i);
            step();
        end
        idle();
        #1;
        chk("pre_af0", almost_full[0], 1'b0);
        chk("pre_cnt1", cnt(1), 3'd2);
        push = 1'b1; push_id = 2'd0; data_in = 32'h30;
        pop = 1'b1; pop_id = 2'd1;
        step();
        idle();
        chk("xch_cnt0", cnt(0), 3'd3);
        chk("xch_cnt1", cnt(1), 3'd1);
        chk("xch_af0", almost_full[0], 1'b1);
        chk("xch_full0", full[0], 1'b0);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", count, 12'h0);
        chk("arst_valid", valid, 4'h0);
        chk("arst_afull", almost_full, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        push = 1'b1; push_id = 2'd0; data_in = 32'h7;
        step();
        idle();
        pop_id = 2'd0;
        #1;
        chk("arst_first", data_out, 32'h7);
        chk("arst_cnt0", cnt(0), 3'd1);

        // Push to empty ch3 with same-cycle pop on ch3.
        push = 1'b1; push_id = 2'd3; data_in = 32'hB;
        pop = 1'b1; pop_id = 2'd3;
        step();
        idle();
        chk("pe_cnt3", cnt(3), 3'd1);
        chk("pe_unf", underflow, 1'b1);
        chk("pe_data", data_out, 32'hB);

        // Depth-3 wrap on channel 0 of the second instance.
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk("w_rst", c3, 8'h0);
        pop_id = 2'd0;
        for (int k = 1; k <= 12; k++) begin
            push    = (k <= 10);
            push_id = 2'd0;
            data_in = 32'(k);
            pop     = (k >= 3);
            #1;
            if (k >= 3)
                chk("w_order", d3_out, 32'(k - 2));
            step();
            chk("w_le3", (c3[1:0] <= 2'd3) && !f3[0], 1'b1);
        end
        idle();
        #1;
        chk("w_empty", v3, 4'h0);
        chk("w_unf", un3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
